// File: rtl/pipe_stage_buf_pkg.sv
// Shared state encoding and default widths for the two-entry pipeline buffer.
package CPU_buffer_bus;

   localparam int PIPE_BUF_DATA_W  = 64;
   localparam int PIPE_BUF_TRACE_W = 96;

   // The encoding doubles as the entry count driven on occupancy.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_buf_state_e;

   function automatic logic [1:0] pipe_buf_occ(input pipe_buf_state_e s);
      return logic'(s == FULL) ? 2'd2 : ((s == BUSY) ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer (head + skid); optional trace sideband under TRACE_EN.
// Latency: one cycle from in_valid/in_ready to out_valid/out_data.
// Backpressure: in_ready drops only when both entries are held; it depends on registered state alone.
module pipe_stage_buf
   import CPU_buffer_bus::*;
#(
   parameter int DATA_W  = PIPE_BUF_DATA_W,
   parameter int TRACE_W = PIPE_BUF_TRACE_W
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               flush_en,
   input  logic               stall_en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
`ifdef TRACE_EN
   input  logic [TRACE_W-1:0] trace_in,
   output logic [TRACE_W-1:0] trace_out,
`endif
   output logic [1:0]         occupancy
);

   // Trace bits ride in the upper part of each stored entry.
`ifdef TRACE_EN
   localparam int TRACE_BITS = TRACE_W;
`else
   localparam int TRACE_BITS = 0 * TRACE_W;
`endif
   localparam int ENT_W = DATA_W + TRACE_BITS;

   pipe_buf_state_e  state_q, state_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic [ENT_W-1:0] skid_q, skid_d;
   logic [ENT_W-1:0] in_ent;
   logic             in_fire;
   logic             out_fire;

`ifdef TRACE_EN
   assign in_ent    = {trace_in, in_data};
   assign trace_out = head_q[ENT_W-1:DATA_W];
`else
   assign in_ent    = in_data;
`endif

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_q[DATA_W-1:0];
   assign occupancy = pipe_buf_occ(state_q);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready & ~stall_en;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush_en) begin
         state_d = EMPTY;
         head_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = BUSY;
                  head_d  = in_ent;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  head_d = in_ent;
               end else if (in_fire) begin
                  state_d = FULL;
                  skid_d  = in_ent;
               end else if (out_fire) begin
                  state_d = EMPTY;
                  head_d  = '0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d = BUSY;
                  head_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = EMPTY;
               head_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits, legal range 1..1024.
REQ-002 Parameter TRACE_W, default 96: trace sideband width in bits; used only when TRACE_EN is defined.
REQ-003 ACLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 ARESET  input  1  reset, synchronous, active-high.
REQ-005 flush_en  input  1  discards all held entries.
REQ-006 stall_en  input  1  freezes the output side; no entry is consumed.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  DATA_W  payload of the head entry.
REQ-013 occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 Storage: head register (drives out_data) plus one skid register; the buffer is 2-deep.
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & !stall_en.
REQ-016 State machine: EMPTY (0 entries), BUSY (head only), FULL (head + skid); occupancy encodes 0/1/2.
REQ-017 EMPTY: in_fire -> BUSY, head <= in_data; otherwise hold.
REQ-018 BUSY, in_fire & out_fire: stay BUSY, head <= in_data.
REQ-019 BUSY, in_fire & !out_fire: -> FULL, skid <= in_data.
REQ-020 BUSY, !in_fire & out_fire: -> EMPTY, head <= 0.
REQ-021 FULL: out_fire -> BUSY, head <= skid, skid <= 0; otherwise hold.
REQ-022 in_ready = (state != FULL); it is a function of registered state only, with no combinational path from out_ready or stall_en.
REQ-023 out_valid = (state != EMPTY).
REQ-024 Latency: data accepted into EMPTY appears on out_data one cycle later; throughput is one entry per cycle when out_ready=1 and stall_en=0.
REQ-025 Order is strictly FIFO; no entry is duplicated or dropped except by flush_en or ARESET.
REQ-026 stall_en=1 behaves as out_ready=0; in_fire is still allowed while state != FULL.
REQ-027 flush_en=1: next state EMPTY, head and skid <= 0; an in_fire in the same cycle is discarded.
REQ-028 Priority: ARESET > flush_en > stall_en > normal handshake.

Reset
REQ-029 ARESET=1 at a clock edge: state EMPTY, head=0, skid=0; hence out_valid=0, out_data=0, occupancy=0, in_ready=1 in the following cycle.
REQ-030 Reset asserted mid-transfer discards all entries; the upstream must re-offer them.

Configuration
REQ-031 Macro TRACE_EN defined: ports trace_in (input, TRACE_W) and trace_out (output, TRACE_W) exist; trace data is stored in both entries and moved, zeroed, flushed and reset exactly like the payload.
REQ-032 TRACE_EN undefined: trace ports and storage are absent; payload behaviour is identical.

Structure
REQ-033 The state enum pipe_buf_state_e (EMPTY, BUSY, FULL; 2 bits) and default width constants live in the shared CPU_buffer_bus package.
REQ-034 Single module with no sub-module; control FSM and datapath are in one file.

Verification
REQ-035 Reset, then in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5 one cycle later; occupancy=1.
REQ-036 out_ready=0, offer 0x11 then 0x22 -> occupancy=2, in_ready=0; third offer 0x33 held. Release out_ready -> outputs 0x11, 0x22, 0x33 in order.
REQ-037 FULL (0x11, 0x22), stall_en=1, out_ready=1 for 3 cycles -> out_data stays 0x11, occupancy stays 2; drop stall_en -> 0x11 then 0x22 drain.
REQ-038 occupancy=2, flush_en=1 with in_valid=1, in_data=0x44 -> next cycle occupancy=0, out_valid=0, out_data=0, and 0x44 never appears.
REQ-039 Streaming 0x01..0x10 with out_ready=1 -> 16 outputs on 16 consecutive cycles, in_ready never 0.
REQ-040 TRACE_EN build: trace_in=0xBEEF paired with data 0x5 -> trace_out=0xBEEF in the same cycle that out_data=0x5; after flush, trace_out=0.
